// File: rtl/tilt_sample_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : tilt_sample_packer_if
//  Description : Sample-in / packed-word-out bundle for tilt_sample_packer.
//  Revision    : 1.0  initial release
// ============================================================================
interface tilt_sample_packer_if #(
  parameter int SAMPLE_W = 13
);
  logic                       enable;
  logic                       s_valid;
  logic signed [SAMPLE_W-1:0] s_x;
  logic signed [SAMPLE_W-1:0] s_y;
  logic [31:0]                data_out;
  logic                       out_strobe;

  modport master (
    output enable,
    output s_valid,
    output s_x,
    output s_y,
    input  data_out,
    input  out_strobe
  );

  modport slave (
    input  enable,
    input  s_valid,
    input  s_x,
    input  s_y,
    output data_out,
    output out_strobe
  );
endinterface
`default_nettype wire

// File: rtl/tilt_sample_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tilt_sample_packer
//  Description : Averages X/Y tilt samples over 2^LOG2_AVG and publishes a
//                coherent packed word {seq, 0, clip, avgY, avgX} for PIO reads.
//  Revision    : 1.0  initial release
// ============================================================================
module tilt_sample_packer #(
  parameter int SAMPLE_W = 13,
  parameter int LOG2_AVG = 3
) (
  input  wire logic           clk,
  input  wire logic           reset,
  tilt_sample_packer_if.slave bus
);

  localparam int ACC_W = SAMPLE_W + LOG2_AVG;
  localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;

  localparam logic [CNT_W-1:0]           c_last_cnt = CNT_W'((1 << LOG2_AVG) - 1);
  localparam logic signed [SAMPLE_W-1:0] c_smin     = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic signed [SAMPLE_W-1:0] c_smax     = {1'b0, {(SAMPLE_W-1){1'b1}}};

  // Stage 1: running window
  logic signed [ACC_W-1:0] acc_x_q, acc_x_d;
  logic signed [ACC_W-1:0] acc_y_q, acc_y_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    clip_acc_q, clip_acc_d;

  // Stage 2: completed window awaiting commit
  logic signed [ACC_W-1:0] sum_x_q, sum_x_d;
  logic signed [ACC_W-1:0] sum_y_q, sum_y_d;
  logic                    clip_fin_q, clip_fin_d;
  logic                    pending_q, pending_d;

  // Published state
  logic [31:0]             data_q, data_d;
  logic                    strobe_q, strobe_d;
  logic [3:0]              seq_q, seq_d;

  logic signed [ACC_W-1:0]    w_x_ext, w_y_ext;
  logic signed [ACC_W-1:0]    w_sum_x_new, w_sum_y_new;
  logic                       w_clip;
  logic signed [SAMPLE_W-1:0] w_avg_x, w_avg_y;
  logic signed [12:0]         w_avg_x13, w_avg_y13;
  logic [3:0]                 w_seq_next;

  assign w_x_ext     = ACC_W'(bus.s_x);
  assign w_y_ext     = ACC_W'(bus.s_y);
  assign w_sum_x_new = acc_x_q + w_x_ext;
  assign w_sum_y_new = acc_y_q + w_y_ext;

  assign w_clip = (bus.s_x == c_smin) || (bus.s_x == c_smax) ||
                  (bus.s_y == c_smin) || (bus.s_y == c_smax);

  // Arithmetic shift floors; the quotient always fits back in SAMPLE_W bits.
  assign w_avg_x    = SAMPLE_W'(sum_x_q >>> LOG2_AVG);
  assign w_avg_y    = SAMPLE_W'(sum_y_q >>> LOG2_AVG);
  assign w_avg_x13  = 13'(w_avg_x);
  assign w_avg_y13  = 13'(w_avg_y);
  assign w_seq_next = seq_q + 4'd1;

  always_comb begin
    acc_x_d    = acc_x_q;
    acc_y_d    = acc_y_q;
    count_d    = count_q;
    clip_acc_d = clip_acc_q;
    sum_x_d    = sum_x_q;
    sum_y_d    = sum_y_q;
    clip_fin_d = clip_fin_q;
    pending_d  = 1'b0;
    data_d     = data_q;
    strobe_d   = 1'b0;
    seq_d      = seq_q;

    if (pending_q) begin
      seq_d    = w_seq_next;
      data_d   = {w_seq_next, 1'b0, clip_fin_q, w_avg_y13, w_avg_x13};
      strobe_d = 1'b1;
    end

    if (!bus.enable) begin
      acc_x_d    = '0;
      acc_y_d    = '0;
      count_d    = '0;
      clip_acc_d = 1'b0;
    end else if (bus.s_valid) begin
      if (count_q == c_last_cnt) begin
        // Hand the finished window to stage 2 and restart stage 1 on the same edge.
        sum_x_d    = w_sum_x_new;
        sum_y_d    = w_sum_y_new;
        clip_fin_d = clip_acc_q | w_clip;
        pending_d  = 1'b1;
        acc_x_d    = '0;
        acc_y_d    = '0;
        count_d    = '0;
        clip_acc_d = 1'b0;
      end else begin
        acc_x_d    = w_sum_x_new;
        acc_y_d    = w_sum_y_new;
        count_d    = count_q + CNT_W'(1);
        clip_acc_d = clip_acc_q | w_clip;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      count_q    <= '0;
      clip_acc_q <= 1'b0;
      sum_x_q    <= '0;
      sum_y_q    <= '0;
      clip_fin_q <= 1'b0;
      pending_q  <= 1'b0;
      data_q     <= '0;
      strobe_q   <= 1'b0;
      seq_q      <= '0;
    end else begin
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      count_q    <= count_d;
      clip_acc_q <= clip_acc_d;
      sum_x_q    <= sum_x_d;
      sum_y_q    <= sum_y_d;
      clip_fin_q <= clip_fin_d;
      pending_q  <= pending_d;
      data_q     <= data_d;
      strobe_q   <= strobe_d;
      seq_q      <= seq_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.out_strobe = strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_tilt_sample_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tilt_sample_packer
//  Description : Self-checking bench for tilt_sample_packer (13b/avg8 and 12b/avg1).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tilt_sample_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nmis = 0;

  always #5 clk = ~clk;

  tilt_sample_packer_if #(.SAMPLE_W(13)) bus_a ();
  tilt_sample_packer_if #(.SAMPLE_W(12)) bus_b ();

  tilt_sample_packer #(.SAMPLE_W(13), .LOG2_AVG(3)) dut_a (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_a.slave)
  );

  tilt_sample_packer #(.SAMPLE_W(12), .LOG2_AVG(0)) dut_b (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_b.slave)
  );

  // Stimulus as plain integers, mirrored onto the buses
  bit en_s = 1'b0;
  bit v_s  = 1'b0;
  int xs[2];
  int ys[2];

  // Reference model: window contents as plain sums, one pending result, published word
  int          wid[2]  = '{13, 12};
  int          lg[2]   = '{3, 0};
  longint      wsx[2], wsy[2], psx[2], psy[2];
  int          wcnt[2];
  bit          wclip[2], pend[2], pclip[2], estrobe[2];
  int          eseq[2];
  logic [31:0] eword[2];

  function automatic longint floordiv(input longint s, input int l);
    longint n, q;
    n = longint'(1) << l;
    q = s / n;
    if ((s % n) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic bit is_clip(input int v, input int w);
    return (v == -(1 << (w - 1))) || (v == (1 << (w - 1)) - 1);
  endfunction

  function automatic logic [31:0] pack(input longint ax, input longint ay, input bit c, input int s);
    logic [31:0] r;
    r[12:0]  = 13'(ax);
    r[25:13] = 13'(ay);
    r[26]    = c;
    r[27]    = 1'b0;
    r[31:28] = 4'(s);
    return r;
  endfunction

  task automatic model_step(input int d);
    if (rst) begin
      wsx[d] = 0; wsy[d] = 0; wcnt[d] = 0; wclip[d] = 0;
      pend[d] = 0; eseq[d] = 0; eword[d] = '0; estrobe[d] = 0;
    end else begin
      estrobe[d] = 0;
      if (pend[d]) begin
        eseq[d]    = (eseq[d] + 1) % 16;
        eword[d]   = pack(floordiv(psx[d], lg[d]), floordiv(psy[d], lg[d]), pclip[d], eseq[d]);
        estrobe[d] = 1;
        pend[d]    = 0;
      end
      if (!en_s) begin
        wsx[d] = 0; wsy[d] = 0; wcnt[d] = 0; wclip[d] = 0;
      end else if (v_s) begin
        wsx[d]   += xs[d];
        wsy[d]   += ys[d];
        wclip[d] |= is_clip(xs[d], wid[d]) || is_clip(ys[d], wid[d]);
        wcnt[d]++;
        if (wcnt[d] == (1 << lg[d])) begin
          pend[d] = 1; psx[d] = wsx[d]; psy[d] = wsy[d]; pclip[d] = wclip[d];
          wsx[d] = 0; wsy[d] = 0; wcnt[d] = 0; wclip[d] = 0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step(0);
    model_step(1);
  end

  task automatic compare(input string name, input logic [32:0] act, input logic [32:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s at %0t: got strobe=%b word=%08h, expected strobe=%b word=%08h",
               name, $time, act[32], act[31:0], exp[32], exp[31:0]);
    end
  endtask

  // Every cycle, both outputs of both instances against the model
  initial forever begin
    @(negedge clk);
    compare("cycle_a", {bus_a.out_strobe, bus_a.data_out}, {estrobe[0], eword[0]});
    compare("cycle_b", {bus_b.out_strobe, bus_b.data_out}, {estrobe[1], eword[1]});
  end

  task automatic cyc(input bit en, input bit v, input int x, input int y, input int x2, input int y2);
    en_s = en; v_s = v;
    xs[0] = x;  ys[0] = y;
    xs[1] = x2; ys[1] = y2;
    bus_a.enable = en; bus_a.s_valid = v; bus_a.s_x = 13'(x);  bus_a.s_y = 13'(y);
    bus_b.enable = en; bus_b.s_valid = v; bus_b.s_x = 12'(x2); bus_b.s_y = 12'(y2);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    rst = 1'b0;
  endtask

  task automatic samp_a(input int x, input int y);
    cyc(1'b1, 1'b1, x, y, 0, 0);
  endtask

  function automatic int rsamp(input int w);
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return -(1 << (w - 1));
    if (r == 1) return (1 << (w - 1)) - 1;
    return int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
  endfunction

  initial begin
    cyc(1'b0, 1'b0, 0, 0, 0, 0);
    do_reset();
    compare("reset_a", {bus_a.out_strobe, bus_a.data_out}, 33'h0);

    // Constant window
    for (int i = 0; i < 8; i++) samp_a(100, -50);
    idle();
    compare("const_100_m50", {bus_a.out_strobe, bus_a.data_out}, {1'b1, 32'h13F9C064});

    // Floor rounding
    do_reset();
    for (int i = 0; i < 8; i++) samp_a(i, 0);
    idle();
    compare("floor_0to7", {bus_a.out_strobe, bus_a.data_out}, {1'b1, 32'h10000003});
    for (int i = 0; i < 7; i++) samp_a(-1, 0);
    samp_a(-2, 0);
    idle();
    compare("floor_m9", {bus_a.out_strobe, bus_a.data_out}, {1'b1, 32'h20001FFE});

    // Back-to-back windows, sample on the commit cycle joins the next window
    do_reset();
    for (int i = 0; i < 16; i++) begin
      samp_a(i, 0);
      if (i == 8) compare("stream_w1", {bus_a.out_strobe, bus_a.data_out}, {1'b1, 32'h10000003});
    end
    idle();
    compare("stream_w2", {bus_a.out_strobe, bus_a.data_out}, {1'b1, 32'h2000000B});

    // Clip flag set, then cleared by the following clean window
    do_reset();
    for (int i = 0; i < 7; i++) samp_a(0, 0);
    samp_a(4095, 0);
    idle();
    compare("clip_set", {bus_a.out_strobe, bus_a.data_out}, {1'b1, 32'h140001FF});
    for (int i = 0; i < 8; i++) samp_a(1, 1);
    idle();
    compare("clip_clear", {bus_a.out_strobe, bus_a.data_out}, {1'b1, 32'h20002001});

    // 12-bit pass-through instance at its negative limit
    do_reset();
    cyc(1'b1, 1'b1, 0, 0, -2048, 0);
    idle();
    compare("b_min_clip", {bus_b.out_strobe, bus_b.data_out}, {1'b1, 32'h14001800});

    // Enable drop discards a partial window
    do_reset();
    for (int i = 0; i < 5; i++) samp_a(7, 0);
    cyc(1'b0, 1'b1, 7, 0, 0, 0);
    for (int i = 0; i < 8; i++) samp_a(20, 0);
    idle();
    compare("en_drop", {bus_a.out_strobe, bus_a.data_out}, {1'b1, 32'h10000014});

    // Enable drop right after the final sample still commits
    do_reset();
    for (int i = 0; i < 8; i++) samp_a(5, 0);
    cyc(1'b0, 1'b0, 0, 0, 0, 0);
    compare("en_drop_pending", {bus_a.out_strobe, bus_a.data_out}, {1'b1, 32'h10000005});

    // Sequence wraps after 16 windows
    do_reset();
    for (int i = 0; i < 128; i++) samp_a(3, 0);
    idle();
    compare("seq_wrap", {bus_a.out_strobe, bus_a.data_out}, {1'b1, 32'h00000003});

    // Reset while a commit is pending drops it
    do_reset();
    for (int i = 0; i < 8; i++) samp_a(9, 0);
    rst = 1'b1;
    idle();
    compare("rst_pending", {bus_a.out_strobe, bus_a.data_out}, 33'h0);
    rst = 1'b0;
    idle();
    compare("rst_pending_after", {bus_a.out_strobe, bus_a.data_out}, 33'h0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      cyc($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0,
          rsamp(13), rsamp(13), rsamp(12), rsamp(12));
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tilt_sample_packer.md
Name: tilt_sample_packer

Overview:
- Upstream feeder for the 32-bit PIO input port that software polls for tilt data.
- Accepts raw signed X/Y accelerometer samples from the sensor-reader stage and averages them over 2^LOG2_AVG samples.
- Packs each average, a clip flag and a sequence counter into one 32-bit word.
- Holds that word stable until the next window completes, so single asynchronous PIO reads are always coherent.

Parameters:
- SAMPLE_W, 13, width of signed input samples; legal range 8..13.
- LOG2_AVG, 3, log2 of the window length; window N = 2^LOG2_AVG; legal range 0..6.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = averaging active; 0 = window discarded and held clear.
- s_valid  in  1  sample strobe; one sample per cycle when high; no backpressure.
- s_x  in  SAMPLE_W  signed X-axis sample.
- s_y  in  SAMPLE_W  signed Y-axis sample.
- data_out  out  32  packed word; drives the PIO in_port.
- out_strobe  out  1  one-cycle pulse on the cycle data_out first shows a new word.

Behaviour:
- Packing:
  - data_out[12:0] = avg X, sign-extended to 13 bits.
  - data_out[25:13] = avg Y, sign-extended to 13 bits.
  - data_out[26] = clip flag.
  - data_out[27] = 0.
  - data_out[31:28] = seq.
- Reset (synchronous, highest priority):
  - data_out = 0, out_strobe = 0, seq = 0.
  - Sample count = 0, accumulators = 0, clip accumulator = 0.
  - A pending stage-2 commit is dropped.
- Accumulators: signed, SAMPLE_W+LOG2_AVG bits each; they cannot overflow.
- Stage 1 (accumulate), on edge with enable=1 and s_valid=1:
  - If count < N-1: acc += sample, count += 1, clip_acc |= clip(sample).
  - If count == N-1:
    - Register final sums (acc + sample) and final clip into the commit stage, and set commit_pending.
    - Clear acc, count and clip_acc on the same edge.
- clip(sample) is true when the X or Y sample equals -2^(SAMPLE_W-1) or 2^(SAMPLE_W-1)-1.
- Stage 2 (commit), on the edge after commit_pending sets:
  - avg = sum >>> LOG2_AVG (arithmetic shift, rounds toward minus infinity).
  - data_out is loaded with avg X, avg Y, clip and seq+1; seq increments with modulo-16 wrap.
  - out_strobe = 1 for exactly that one cycle; commit_pending clears.
- Latency: the Nth sample is accepted at edge k; data_out updates and out_strobe asserts after edge k+1.
- Throughput: continuous s_valid is supported.
  - A sample on the commit cycle belongs to the next window (count 0 → 1).
  - No sample is lost.
- LOG2_AVG = 0: every valid sample commits; output is a pass-through with 2-cycle latency.
- enable = 0:
  - Stage 1 clears acc, count and clip_acc every cycle; s_valid is ignored.
  - A commit already pending in stage 2 still completes.
  - data_out and seq otherwise hold.
- Re-enable: a new window starts fresh at count 0.
- data_out changes only on reset or a commit edge; it never shows a partial window.

Test Plan:
- LOG2_AVG=3, 8 valid cycles with x=100, y=-50 → data_out[12:0]=0x064, [25:13]=0x1FCE, bit26=0, seq=1; out_strobe high exactly one cycle, 2 edges after the 8th sample.
- Floor rounding:
  - x = 0..7 → avg 3.
  - x = seven samples of -1 plus one of -2 (sum -9) → avg -2, i.e. [12:0]=0x1FFE.
- Continuous s_valid for 16 cycles (x = sample index) → two strobes: first word avg 3 with seq=1, second word avg 11 with seq=2. The 9th sample lands in the second window.
- Clip handling:
  - A window containing x=4095 → bit26=1.
  - The next window, all samples in range → bit26=0.
  - SAMPLE_W=12, a window of x=-2048 → bit26=1 and [12:0]=0x1800.
- Enable drop:
  - enable dropped after 5 samples, then restored, then 8 samples of x=20 → a single strobe, avg 20; the earlier 5 samples are excluded.
  - enable dropped on the cycle after the 8th sample → commit still occurs.
- Reset and wrap:
  - 16 full windows → seq wraps 15 → 0.
  - Reset asserted during the commit-pending cycle → no strobe, data_out=0, seq=0.
